// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module      : fetch_seq
// Description : Instruction fetch sequencer. Reads four bytes from a
//               byte-wide combinational ROM and assembles them big-endian
//               into a 32-bit instruction word. The word is then offered on a
//               valid/ready handshake. Supports redirects (jumps/branches)
//               and wraps the PC modulo the ROM size.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               run                 - enable fetching (low parks in IDLE)
//               redirect_valid/_pc  - jump request and byte target
//               rom_addr/rom_data   - byte ROM address out, read data in
//               instr/instr_pc      - assembled word and its byte address
//               instr_valid/_ready  - output handshake
//               instr_count         - accepted-word counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_seq #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_count
);

  // PC and byte addresses are kept only as wide as the ROM needs, so the
  // modulo-ROM_BYTES wrap falls out of the natural overflow of the adders.
  localparam int AW = $clog2(ROM_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] pc;
  logic [1:0]    cnt;
  logic          handshake;
  logic [AW-1:0] byte_addr;
  logic          unused_ok;

  // Low two bits of the redirect target are forced to word alignment and
  // bits above the ROM depth are dropped by the modulo.
  assign unused_ok = ^{redirect_pc[31:AW], redirect_pc[1:0]};

  assign handshake = (state == S_HOLD) && instr_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      // Redirect outranks every other transition.
      state_nxt = run ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = run ? S_FETCH : S_IDLE;
        S_FETCH: state_nxt = (cnt == 2'd3) ? S_HOLD : S_FETCH;
        S_HOLD:  if (instr_ready) state_nxt = run ? S_FETCH : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    instr_valid = (state == S_HOLD);
    byte_addr   = pc;
    if (state == S_FETCH) begin
      byte_addr = pc + {{(AW-2){1'b0}}, cnt};
    end
    rom_addr = {{(32-AW){1'b0}}, byte_addr};
  end

  // pc only advances on a handshake, so it still names the held word.
  assign instr_pc = {{(32-AW){1'b0}}, pc};

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC[AW-1:0];
      cnt         <= 2'd0;
      instr       <= 32'h0;
      instr_count <= 16'h0;
    end else begin
      // A handshake coinciding with a redirect is still counted.
      if (handshake) begin
        instr_count <= instr_count + 16'd1;
      end

      if (redirect_valid) begin
        pc    <= {redirect_pc[AW-1:2], 2'b00};
        cnt   <= 2'd0;
        instr <= 32'h0;
      end else if (handshake) begin
        pc <= pc + AW'(4);
      end else if (state == S_FETCH) begin
        case (cnt)
          2'd0:    instr[31:24] <= rom_data;
          2'd1:    instr[23:16] <= rom_data;
          2'd2:    instr[15:8]  <= rom_data;
          default: instr[7:0]   <= rom_data;
        endcase
        // Wraps 3 -> 0 on the cycle that moves to HOLD.
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 Parameter: ROM_BYTES, default 128, the byte depth of the instruction ROM (power of two).
REQ-003 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: run  input  1  enables fetching; low parks the sequencer in IDLE.
REQ-006 Port: redirect_valid  input  1  requests a jump or branch to redirect_pc.
REQ-007 Port: redirect_pc  input  32  byte address of the redirect target.
REQ-008 Port: rom_addr  output  32  byte address presented to the byte-wide instruction ROM.
REQ-009 Port: rom_data  input  8  combinational ROM read data for rom_addr, valid in the same cycle.
REQ-010 Port: instr  output  32  assembled instruction word, big-endian.
REQ-011 Port: instr_pc  output  32  byte address of the word held on instr.
REQ-012 Port: instr_valid  output  1  instr and instr_pc are valid.
REQ-013 Port: instr_ready  input  1  consumer accepts the word.
REQ-014 Port: instr_count  output  16  count of accepted words; wraps from 16'hFFFF to 0.

Function
REQ-015 The state machine SHALL have three states: IDLE, FETCH and HOLD; a 2-bit byte counter cnt SHALL be used only in FETCH.
REQ-016 rom_addr SHALL equal (pc + cnt) mod ROM_BYTES, zero-extended to 32 bits; in IDLE and HOLD it SHALL be pc mod ROM_BYTES.
REQ-017 In FETCH, each cycle SHALL latch rom_data into the byte lane for cnt: cnt 0 into [31:24], 1 into [23:16], 2 into [15:8], 3 into [7:0].
REQ-018 FETCH SHALL increment cnt each cycle; in the cycle where cnt==3 it SHALL go to HOLD with cnt reset to 0.
REQ-019 Latency SHALL be 4 FETCH cycles; instr_valid SHALL be asserted in the first HOLD cycle, which is the 5th edge after FETCH entry.
REQ-020 instr_valid SHALL be 1 only in HOLD; instr and instr_pc SHALL remain stable while instr_valid=1 and instr_ready=0.
REQ-021 A handshake occurs when instr_valid and instr_ready are both 1; it SHALL set pc to (pc+4) mod ROM_BYTES and increment instr_count by 1.
REQ-022 After a handshake, the next state SHALL be FETCH if run=1, otherwise IDLE.
REQ-023 In IDLE with run=1, the next state SHALL be FETCH with cnt=0; with run=0, the sequencer SHALL remain in IDLE.
REQ-024 Deasserting run during FETCH or HOLD SHALL NOT abort the operation; the sequencer returns to IDLE only after the next handshake.
REQ-025 Redirect priority: redirect_valid=1 SHALL override all other transitions in any state.
REQ-026 On a redirect, pc SHALL load (redirect_pc & ~3) mod ROM_BYTES, cnt SHALL clear, and the next state SHALL be FETCH if run=1, otherwise IDLE.
REQ-027 On a redirect, instr_valid SHALL be 0 from the next cycle; a partially assembled word SHALL be discarded.
REQ-028 A redirect in the same cycle as a handshake SHALL count the handshake (instr_count+1), and the redirect target SHALL replace pc+4.
REQ-029 PC wrap: a word at ROM_BYTES-4 followed by a handshake SHALL give pc=0; byte addresses SHALL never exceed ROM_BYTES-1.
REQ-030 instr_pc SHALL equal the pc value of the word being held, taken modulo ROM_BYTES.

Reset
REQ-031 With rst=1 at a rising edge: state SHALL be IDLE, pc=RESET_PC mod ROM_BYTES, cnt=0, instr=0, instr_valid=0, instr_count=0; rst SHALL take priority over redirect and handshake.
REQ-032 Reset asserted mid-FETCH or in HOLD SHALL discard the word in progress; no partial word SHALL be visible afterwards.

Verification
REQ-033 Reset, then run=1, ROM[0..3]=20 11 00 05, instr_ready=1 -> instr_valid=1 on the 5th edge after FETCH entry, instr=32'h2011_0005, instr_pc=0; then instr_count=1 and pc=4.
REQ-034 Hold instr_ready=0 for 6 cycles in HOLD -> instr, instr_pc and instr_valid stay stable; after instr_ready=1 for one cycle, instr_count increments by 1.
REQ-035 redirect_valid=1, redirect_pc=32'h0000_0013 during cnt=2 -> partial word discarded, next FETCH starts at rom_addr=0x10, and instr_pc=0x10 at the next valid word.
REQ-036 Word at pc=0x7C accepted -> the next fetch rom_addr sequence is 0,1,2,3 and instr_pc=0.
REQ-037 Redirect to 0x40 in the same cycle as a handshake at pc=8 -> instr_count increments and the next instr_pc is 0x40, not 0x0C.
REQ-038 rst=1 asserted in HOLD with instr_valid=1 -> next cycle instr_valid=0, instr_count=0, state IDLE, pc=RESET_PC.
